// File: rtl/pwm_mode_detector.sv
// Decodes the duty class of a PWM line (25/50/75 %) from cycle counts of each
// period, and flags idle, stuck-high and out-of-range duty conditions.
module pwm_mode_detector #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm,
    output logic [1:0]       mode,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int             XW  = CNT_W + 3;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    // valid and err are single-cycle pulses with no backpressure; mode,
    // high_cnt and period_cnt change only in the cycle valid is high.

    logic             s1, s2, s3;
    logic             rise, fall;
    state_t           state, state_n;
    logic [CNT_W-1:0] hcnt, hcnt_n, pcnt, pcnt_n, pinc;

    // Decision stage, one cycle ahead of the output registers.
    logic             c_valid, c_valid_n;
    logic             c_err, c_err_n;
    logic [1:0]       c_mode, c_mode_n;
    logic [CNT_W-1:0] c_h, c_h_n, c_p, c_p_n;

    logic [XW-1:0]    h8, p1, p3, p5, p7;
    logic [1:0]       cls_mode;
    logic             cls_bad;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign pinc      = pcnt + 1'b1;
    assign dbg_state = state;

    // Ratio bands compared as 8H against odd multiples of P, widened so
    // nothing truncates.
    always_comb begin
        h8       = {hcnt, 3'b000};
        p1       = XW'(pcnt);
        p3       = p1 + (p1 << 1);
        p5       = p1 + (p1 << 2);
        p7       = (p1 << 3) - p1;
        cls_bad  = (h8 < p1) || (h8 >= p7);
        cls_mode = 2'd1;
        if (h8 >= p5) begin
            cls_mode = 2'd3;
        end else if (h8 >= p3) begin
            cls_mode = 2'd2;
        end
    end

    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        pcnt_n    = pcnt;
        c_valid_n = 1'b0;
        c_err_n   = 1'b0;
        c_mode_n  = c_mode;
        c_h_n     = c_h;
        c_p_n     = c_p;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = 1;
                    pcnt_n  = 1;
                end else if (!s2 && pcnt != TMO) begin
                    pcnt_n = pinc;
                    if (pinc == TMO) begin
                        c_valid_n = 1'b1;
                        c_mode_n  = 2'd0;
                        c_h_n     = '0;
                        c_p_n     = '0;
                    end
                end
            end
            HIGH: begin
                pcnt_n = pinc;
                if (fall) begin
                    if (pinc == TMO) begin
                        state_n   = IDLE;
                        c_valid_n = 1'b1;
                        c_mode_n  = 2'd0;
                        c_h_n     = '0;
                        c_p_n     = '0;
                    end else begin
                        state_n = LOW;
                    end
                end else if (pinc == TMO) begin
                    state_n = IDLE;
                    c_err_n = 1'b1;
                    hcnt_n  = '0;
                    pcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    if (cls_bad) begin
                        c_err_n = 1'b1;
                    end else begin
                        c_valid_n = 1'b1;
                        c_mode_n  = cls_mode;
                        c_h_n     = hcnt;
                        c_p_n     = pcnt;
                    end
                    state_n = HIGH;
                    hcnt_n  = 1;
                    pcnt_n  = 1;
                end else begin
                    pcnt_n = pinc;
                    if (pinc == TMO) begin
                        state_n   = IDLE;
                        c_valid_n = 1'b1;
                        c_mode_n  = 2'd0;
                        c_h_n     = '0;
                        c_p_n     = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                hcnt_n  = '0;
                pcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            c_valid    <= 1'b0;
            c_err      <= 1'b0;
            c_mode     <= 2'd0;
            c_h        <= '0;
            c_p        <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            mode       <= 2'd0;
            high_cnt   <= '0;
            period_cnt <= '0;
        end else begin
            s1      <= pwm;
            s2      <= s1;
            s3      <= s2;
            state   <= state_n;
            hcnt    <= hcnt_n;
            pcnt    <= pcnt_n;
            c_valid <= c_valid_n;
            c_err   <= c_err_n;
            c_mode  <= c_mode_n;
            c_h     <= c_h_n;
            c_p     <= c_p_n;
            valid   <= c_valid;
            err     <= c_err;
            if (c_valid) begin
                mode       <= c_mode;
                high_cnt   <= c_h;
                period_cnt <= c_p;
            end
        end
    end

endmodule

// File: tb/tb_pwm_mode_detector.sv
// Directed bench for pwm_mode_detector with TIMEOUT=64: duty classes,
// boundaries, idle and stuck-high timeouts, and reset mid-period.
module tb_pwm_mode_detector;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst;
    logic             pwm;
    logic [1:0]       mode;
    logic             valid;
    logic             err;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [1:0]       dbg_state;

    int n_vec;
    int n_bad;
    int cyc;
    int nvalid, nerr;
    int vcyc, pvcyc;
    int last_rise;
    int v0, e0;

    pwm_mode_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm        (pwm),
        .mode       (mode),
        .valid      (valid),
        .err        (err),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts valid/err pulses and remembers when valid fired.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                nvalid <= nvalid + 1;
                pvcyc  <= vcyc;
                vcyc   <= cyc;
            end
            if (err) nerr <= nerr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one PWM period and returns at a negedge.
    task automatic run_period(input int h, input int p);
        pwm       = 1'b1;
        last_rise = cyc;
        repeat (h) @(negedge clk);
        pwm = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic mark();
        v0 = nvalid;
        e0 = nerr;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        cyc    = 0;
        nvalid = 0;
        nerr   = 0;
        vcyc   = 0;
        pvcyc  = 0;
        rst    = 1'b0;
        pwm    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        chk("rst_mode", 32'(mode), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_high", 32'(high_cnt), 0);
        chk("rst_period", 32'(period_cnt), 0);
        chk("rst_state", 32'(dbg_state), 0);

        // 25 % duty, repeated
        mark();
        for (int i = 0; i < 5; i++) run_period(2, 8);
        chk("m1_valids", 32'(nvalid - v0), 4);
        chk("m1_latency", 32'(vcyc - last_rise), 4);
        chk("m1_spacing", 32'(vcyc - pvcyc), 8);
        chk("m1_mode", 32'(mode), 1);
        chk("m1_high", 32'(high_cnt), 2);
        chk("m1_period", 32'(period_cnt), 8);
        chk("m1_err", 32'(nerr - e0), 0);

        // 50 % then 75 %
        mark();
        for (int i = 0; i < 3; i++) run_period(4, 8);
        chk("m2_mode", 32'(mode), 2);
        chk("m2_high", 32'(high_cnt), 4);
        for (int i = 0; i < 3; i++) run_period(6, 8);
        chk("m3_mode", 32'(mode), 3);
        chk("m3_high", 32'(high_cnt), 6);
        chk("m3_period", 32'(period_cnt), 8);
        chk("m23_err", 32'(nerr - e0), 0);
        chk("m23_valids", 32'(nvalid - v0), 6);

        // 8H == 3P boundary lands in the 50 % class
        for (int i = 0; i < 3; i++) run_period(3, 8);
        chk("b3_mode", 32'(mode), 2);
        chk("b3_high", 32'(high_cnt), 3);

        // 1/16 duty is below range: err, outputs untouched
        mark();
        for (int i = 0; i < 2; i++) run_period(1, 16);
        chk("low_err", 32'(nerr - e0), 1);
        chk("low_valids", 32'(nvalid - v0), 1);
        chk("low_mode", 32'(mode), 2);
        chk("low_high", 32'(high_cnt), 3);
        chk("low_period", 32'(period_cnt), 8);

        // 7/8 duty (8H == 7P) is above range
        mark();
        for (int i = 0; i < 2; i++) run_period(7, 8);
        chk("high_err", 32'(nerr - e0), 2);
        chk("high_valids", 32'(nvalid - v0), 0);
        chk("high_mode", 32'(mode), 2);

        // line held low: one idle report, then silence
        mark();
        pwm = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_valids", 32'(nvalid - v0), 1);
        chk("idle_mode", 32'(mode), 0);
        chk("idle_high", 32'(high_cnt), 0);
        chk("idle_period", 32'(period_cnt), 0);
        chk("idle_err", 32'(nerr - e0), 0);
        mark();
        repeat (100) @(negedge clk);
        chk("idle_repeat", 32'(nvalid - v0), 0);

        // first rise after idle only opens a period
        mark();
        for (int i = 0; i < 3; i++) run_period(2, 8);
        chk("reopen_valids", 32'(nvalid - v0), 2);
        chk("reopen_mode", 32'(mode), 1);

        // stuck high
        mark();
        pwm = 1'b1;
        repeat (80) @(negedge clk);
        chk("stuck_err", 32'(nerr - e0), 1);
        chk("stuck_valids", 32'(nvalid - v0), 1);
        chk("stuck_mode", 32'(mode), 1);
        chk("stuck_state", 32'(dbg_state), 0);
        pwm = 1'b0;
        repeat (10) @(negedge clk);

        // reset in the middle of a high phase
        for (int i = 0; i < 2; i++) run_period(2, 8);
        pwm = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pwm = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mrst_mode", 32'(mode), 0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_err", 32'(err), 0);
        chk("mrst_high", 32'(high_cnt), 0);
        chk("mrst_period", 32'(period_cnt), 0);
        chk("mrst_state", 32'(dbg_state), 0);
        mark();
        repeat (4) @(negedge clk);
        run_period(2, 8);
        chk("mrst_open", 32'(nvalid - v0), 0);
        run_period(2, 8);
        chk("mrst_valids", 32'(nvalid - v0), 1);
        chk("mrst_mode1", 32'(mode), 1);
        chk("mrst_high2", 32'(high_cnt), 2);
        chk("mrst_period8", 32'(period_cnt), 8);
        chk("mrst_errs", 32'(nerr - e0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
